note_sequencer: RTL

Autonomous score player for the two-channel synth (`audio_multichannel`). It holds a small score RAM written by the host. After a start pulse it steps through the score at a fixed time base, driving each channel's enable and frequency, including a per-note articulation gap and a rest. It replaces the hand-written enable/frequency sequencing currently done in benches. Generator select and volume stay with the host register bank.

---
 rtl/audio_seq_pkg.sv | 25 ++
 rtl/seq_score_mem.sv | 34 +++
 rtl/note_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the score sequencer that drives the two-channel synth.
package audio_seq_pkg;

  localparam int unsigned DUR_W   = 12;
  localparam int unsigned FREQ_W  = 16;
  localparam int unsigned ENTRY_W = 2 + FREQ_W + DUR_W;

  typedef struct packed {
    logic              rest;
    logic              ch1_on;
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } seq_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

  localparam logic [FREQ_W-1:0] G4  = 16'd4208;
  localparam logic [FREQ_W-1:0] Dd4 = 16'd3339;
  localparam logic [FREQ_W-1:0] Ad4 = 16'd5005;

endpackage

// File: rtl/seq_score_mem.sv
// Score RAM: single port shared between host writes (idle) and step reads (busy).
module seq_score_mem
  import audio_seq_pkg::*;
#(
  parameter int unsigned STEPS = 16,
  parameter int unsigned AW    = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               busy_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem [STEPS];
  logic [AW-1:0]      addr;

  assign addr = busy_i ? rd_addr_i : wr_addr_i;

  always_ff @(posedge clk) begin
    if (wr_en_i && !busy_i) mem[addr] <= wr_data_i;
  end

  // The read register doubles as the current-entry register; it holds between loads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 rd_data_o <= '0;
    else if (rd_en_i && busy_i) rd_data_o <= mem[addr];
  end

endmodule

// File: rtl/note_sequencer.sv
// Autonomous score player: steps through the score RAM driving channel enables and frequency.
module note_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned STEPS     = 16,
  parameter int unsigned TICK_DIV  = 12500,
  parameter int unsigned GAP_TICKS = 20,
  localparam int unsigned AW       = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [AW-1:0]      last_idx_i,
  input  logic               loop_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [AW-1:0]      step_o,
  output logic               ch0_en_o,
  output logic               ch1_en_o,
  output logic [FREQ_W-1:0]  ch0_freq_o,
  output logic [FREQ_W-1:0]  ch1_freq_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  seq_state_e         state;
  logic [AW-1:0]      step_q;
  logic [AW-1:0]      last_q;
  logic               loop_q;
  logic [PW-1:0]      presc_q;
  logic [DUR_W-1:0]   tick_cnt_q;
  logic               done_q;
  logic [ENTRY_W-1:0] rd_data;
  seq_entry_t         entry;
  logic [DUR_W-1:0]   rem;
  logic               tick;

  seq_score_mem #(.STEPS(STEPS), .AW(AW)) u_mem (
    .clk       (clk),
    .rstn      (rstn),
    .busy_i    (busy_o),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   ((state == ST_LOAD) && !stop_i),
    .rd_addr_i (step_q),
    .rd_data_o (rd_data)
  );

  assign entry = seq_entry_t'(rd_data);
  // Remaining ticks of the current step; tick_cnt_q stays below dur, so this never wraps.
  assign rem   = entry.dur - tick_cnt_q;
  assign tick  = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      step_q     <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            last_q <= last_idx_i;
            loop_q <= loop_i;
            step_q <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          presc_q    <= '0;
          tick_cnt_q <= '0;
          state      <= ST_PLAY;
        end
        ST_PLAY: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (entry.dur == '0) begin
            // End-of-score marker; a marker at step 0 never loops, so an empty score terminates.
            if (loop_q && step_q != '0) begin
              step_q <= '0;
              state  <= ST_LOAD;
            end else begin
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end
          end else if (tick) begin
            if (rem == DUR_W'(1)) begin
              if (step_q < last_q) begin
                step_q <= step_q + AW'(1);
                state  <= ST_LOAD;
              end else if (loop_q) begin
                step_q <= '0;
                state  <= ST_LOAD;
              end else begin
                done_q <= 1'b1;
                state  <= ST_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + DUR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Abort overrides everything, including a completion in the same cycle.
      if (stop_i && state != ST_IDLE) begin
        state  <= ST_IDLE;
        done_q <= 1'b0;
      end
    end
  end

  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done_q;
  assign step_o     = step_q;
  assign ch0_en_o   = (state == ST_PLAY) && !entry.rest && (rem > DUR_W'(GAP_TICKS));
  assign ch1_en_o   = ch0_en_o && entry.ch1_on;
  assign ch0_freq_o = entry.freq;
  assign ch1_freq_o = entry.freq;

endmodule
